// File: rtl/conv_encoder_framed.sv
// conv_encoder_framed
//
// Framed rate-1/2 convolutional encoder, K=3, generators 7/5 (octal).
// Accepts one information bit per handshake and produces one 2-bit code symbol
// per accepted bit. After every FRAME_LEN data bits it appends two zero tail
// bits. The tail drives the trellis back to state 0, so the downstream Viterbi
// decoder can terminate each frame cleanly.
//
// Parameters:
//   FRAME_LEN      information bits per frame (2..65535)
//   G0, G1         generator taps for d_out[1] / d_out[0]; bit 2 taps the input
// Ports:
//   clk            clock
//   rst            synchronous active-high reset
//   enable_i       input bit valid; a bit is accepted when enable_i && ready_o
//   d_in           information bit
//   ready_o        encoder can accept a bit this cycle (combinational)
//   valid_o        one-cycle pulse, d_out holds a new symbol
//   d_out          code symbol {g0 parity, g1 parity}
//   frame_start_o  first symbol of a frame (qualified by valid_o)
//   frame_end_o    last tail symbol of a frame (qualified by valid_o)
//   bit_ct_o       data bits accepted so far in the current frame

module conv_encoder_framed #(
  parameter int         FRAME_LEN = 256,
  parameter logic [2:0] G0        = 3'b111,
  parameter logic [2:0] G1        = 3'b101
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_i,
  input  logic        d_in,
  output logic        ready_o,
  output logic        valid_o,
  output logic [1:0]  d_out,
  output logic        frame_start_o,
  output logic        frame_end_o,
  output logic [15:0] bit_ct_o
);

  localparam logic [15:0] FRAME_LEN_W = 16'(FRAME_LEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [1:0]  sr, sr_next;
  logic [15:0] bit_ct, bit_ct_next;
  logic        tail_ct, tail_ct_next;

  logic        accept;
  logic        step;
  logic        b;
  logic [2:0]  v;
  logic [1:0]  sym;
  logic        sym_start, sym_end;

  // First pipeline stage: the symbol computed on the accept edge is held here
  // and moved to the outputs on the following edge.
  logic        s1_valid, s1_start, s1_end;
  logic [1:0]  s1_sym;

  // Ready is blocked during the tail and while reset is asserted.
  assign ready_o = !rst && (state != TAIL);
  assign accept  = enable_i && ready_o;

  assign bit_ct_o = bit_ct;

  // Next-state logic. A "step" is any cycle that pushes a bit into the shift
  // register: a data accept, or either of the two forced-zero tail cycles.
  always_comb begin
    state_next   = state;
    bit_ct_next  = bit_ct;
    tail_ct_next = tail_ct;
    step         = 1'b0;
    b            = 1'b0;
    sym_start    = 1'b0;
    sym_end      = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          step         = 1'b1;
          b            = d_in;
          sym_start    = 1'b1;
          bit_ct_next  = 16'd1;
          tail_ct_next = 1'b0;
          state_next   = (FRAME_LEN_W == 16'd1) ? TAIL : DATA;
        end
      end
      DATA: begin
        if (accept) begin
          step        = 1'b1;
          b           = d_in;
          bit_ct_next = bit_ct + 16'd1;
          if (bit_ct_next == FRAME_LEN_W) begin
            state_next   = TAIL;
            tail_ct_next = 1'b0;
          end
        end
      end
      TAIL: begin
        step         = 1'b1;
        b            = 1'b0;
        tail_ct_next = 1'b1;
        if (tail_ct) begin
          sym_end     = 1'b1;
          bit_ct_next = 16'd0;
          state_next  = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Encode vector {input, newest past bit, oldest past bit}.
    v   = {b, sr[0], sr[1]};
    sym = {^(v & G0), ^(v & G1)};

    sr_next = sr;
    if (step) begin
      sr_next = {sr[0], b};
    end
    // The two zero tail bits already flush sr; clearing explicitly keeps the
    // next frame's starting state obvious.
    if ((state == TAIL) && tail_ct) begin
      sr_next = 2'b00;
    end
  end

  // State, shift register and the two-stage symbol output pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      sr            <= 2'b00;
      bit_ct        <= 16'd0;
      tail_ct       <= 1'b0;
      s1_valid      <= 1'b0;
      s1_sym        <= 2'b00;
      s1_start      <= 1'b0;
      s1_end        <= 1'b0;
      valid_o       <= 1'b0;
      d_out         <= 2'b00;
      frame_start_o <= 1'b0;
      frame_end_o   <= 1'b0;
    end else begin
      state   <= state_next;
      sr      <= sr_next;
      bit_ct  <= bit_ct_next;
      tail_ct <= tail_ct_next;

      s1_valid <= step;
      s1_start <= step && sym_start;
      s1_end   <= step && sym_end;
      if (step) begin
        s1_sym <= sym;
      end

      valid_o       <= s1_valid;
      frame_start_o <= s1_valid && s1_start;
      frame_end_o   <= s1_valid && s1_end;
      if (s1_valid) begin
        d_out <= s1_sym;
      end
    end
  end

endmodule

// File: tb/tb_conv_encoder_framed.sv
// tb_conv_encoder_framed
//
// Drives two encoder instances (FRAME_LEN=4 and FRAME_LEN=256) and checks
// every cycle against a frame-level model. The model keeps the last two bits
// of the frame's bit stream and derives each parity pair directly from the
// 7/5 generator equations. It schedules every expected symbol, bit count and
// ready window by the cycle on which it must be observed.

module tb_conv_encoder_framed;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [2];
  logic        en    [2];
  logic        din   [2];
  logic        ready [2];
  logic        valid [2];
  logic [1:0]  dout  [2];
  logic        start [2];
  logic        fend  [2];
  logic [15:0] bct   [2];

  conv_encoder_framed #(.FRAME_LEN(4)) dut4 (
    .clk(clk), .rst(rst[0]), .enable_i(en[0]), .d_in(din[0]),
    .ready_o(ready[0]), .valid_o(valid[0]), .d_out(dout[0]),
    .frame_start_o(start[0]), .frame_end_o(fend[0]), .bit_ct_o(bct[0])
  );

  conv_encoder_framed #(.FRAME_LEN(256)) dut256 (
    .clk(clk), .rst(rst[1]), .enable_i(en[1]), .d_in(din[1]),
    .ready_o(ready[1]), .valid_o(valid[1]), .d_out(dout[1]),
    .frame_start_o(start[1]), .frame_end_o(fend[1]), .bit_ct_o(bct[1])
  );

  // Expected symbol, tagged with instance and the negedge index it must show on.
  typedef struct {
    int         d;
    int         cyc;
    logic [1:0] sym;
    logic       st;
    logic       en;
  } exp_t;

  typedef struct {
    int d;
    int cyc;
    int val;
  } ct_t;

  exp_t symq[$];
  ct_t  ctq[$];

  int   flen      [2] = '{4, 256};
  int   cnt       [2];
  logic p1        [2];
  logic p2        [2];
  int   tail_from [2];
  int   cur_ct    [2];
  logic rst_prev  [2];

  int negcnt  = 0;
  int n_cmp   = 0;
  int n_err   = 0;
  int peak1   = 0;
  int valids1 = 0;

  logic [1:0] log0[$];
  logic [1:0] ref6[6] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, negcnt);
    end
  endtask

  // Ready is low while reset is held and for the two cycles after the final data bit.
  function automatic logic model_ready(input int d, input int k);
    return !rst[d] && !((k > tail_from[d]) && (k <= tail_from[d] + 2));
  endfunction

  task automatic model_accept(input int d, input logic b, input int k);
    exp_t e;
    ct_t  c;
    e.d   = d;
    e.cyc = k + 2;
    e.sym = {b ^ p1[d] ^ p2[d], b ^ p2[d]};
    e.st  = (cnt[d] == 0);
    e.en  = 1'b0;
    symq.push_back(e);
    p2[d] = p1[d];
    p1[d] = b;
    cnt[d]++;
    c.d = d; c.cyc = k + 1; c.val = cnt[d];
    ctq.push_back(c);
    if (cnt[d] == flen[d]) begin
      e.cyc = k + 3;
      e.sym = {p1[d] ^ p2[d], p2[d]};
      e.st  = 1'b0;
      symq.push_back(e);
      p2[d] = p1[d];
      p1[d] = 1'b0;
      e.cyc = k + 4;
      e.sym = {p1[d] ^ p2[d], p2[d]};
      e.en  = 1'b1;
      symq.push_back(e);
      p1[d]  = 1'b0;
      p2[d]  = 1'b0;
      cnt[d] = 0;
      c.cyc = k + 3; c.val = 0;
      ctq.push_back(c);
      tail_from[d] = k;
    end
  endtask

  task automatic check_output(input int d);
    int found;
    string tag;
    tag = $sformatf("dut%0d", d);
    for (int i = 0; i < ctq.size(); ) begin
      if (ctq[i].d == d && ctq[i].cyc <= negcnt) begin
        cur_ct[d] = ctq[i].val;
        ctq.delete(i);
      end else begin
        i++;
      end
    end
    found = -1;
    foreach (symq[i]) begin
      if (found < 0 && symq[i].d == d && symq[i].cyc == negcnt) found = i;
    end
    chk({tag, ".ready"}, int'(ready[d]), int'(model_ready(d, negcnt)));
    chk({tag, ".bit_ct"}, int'(bct[d]), cur_ct[d]);
    if (found >= 0) begin
      chk({tag, ".valid"}, int'(valid[d]), 1);
      chk({tag, ".d_out"}, int'(dout[d]), int'(symq[found].sym));
      chk({tag, ".frame_start"}, int'(start[d]), int'(symq[found].st));
      chk({tag, ".frame_end"}, int'(fend[d]), int'(symq[found].en));
      if (d == 0) log0.push_back(dout[0]);
      symq.delete(found);
    end else begin
      chk({tag, ".valid_idle"}, int'(valid[d]), 0);
    end
    if (rst_prev[d]) begin
      chk({tag, ".rst_d_out"}, int'(dout[d]), 0);
      chk({tag, ".rst_start"}, int'(start[d]), 0);
      chk({tag, ".rst_end"}, int'(fend[d]), 0);
    end
    rst_prev[d] = rst[d];
    if (d == 1) begin
      if (int'(bct[1]) > peak1) peak1 = int'(bct[1]);
      if (valid[1]) valids1++;
    end
  endtask

  // Single compare process: every cycle, both instances.
  always @(negedge clk) begin
    negcnt++;
    check_output(0);
    check_output(1);
  end

  task automatic apply_stimulus(input int d, input logic b);
    @(negedge clk);
    #1;
    en[d]  = 1'b1;
    din[d] = b;
    if (model_ready(d, negcnt)) model_accept(d, b, negcnt);
  endtask

  task automatic idle(input int d, input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      en[d] = 1'b0;
    end
  endtask

  task automatic send_frame4();
    apply_stimulus(0, 1'b1);
    apply_stimulus(0, 1'b0);
    apply_stimulus(0, 1'b1);
    apply_stimulus(0, 1'b1);
  endtask

  task automatic do_reset(input int d, input int n);
    int   m;
    ct_t  c;
    @(negedge clk);
    #1;
    rst[d] = 1'b1;
    en[d]  = 1'b1;
    din[d] = 1'b1;
    m = negcnt;
    for (int i = 0; i < symq.size(); ) begin
      if (symq[i].d == d && symq[i].cyc > m) symq.delete(i);
      else i++;
    end
    for (int i = 0; i < ctq.size(); ) begin
      if (ctq[i].d == d && ctq[i].cyc > m) ctq.delete(i);
      else i++;
    end
    c.d = d; c.cyc = m + 1; c.val = 0;
    ctq.push_back(c);
    cnt[d] = 0; p1[d] = 1'b0; p2[d] = 1'b0; tail_from[d] = -100;
    repeat (n - 1) @(negedge clk);
    @(negedge clk);
    #1;
    rst[d] = 1'b0;
    en[d]  = 1'b0;
  endtask

  // Compares the captured FRAME_LEN=4 symbols with the hand-computed sequence.
  task automatic check_log(input string name, input int reps);
    chk({name, ".count"}, log0.size(), 6 * reps);
    for (int i = 0; i < log0.size() && i < 6 * reps; i++) begin
      chk($sformatf("%s.sym%0d", name, i), int'(log0[i]), int'(ref6[i % 6]));
    end
    log0.delete();
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; en[d] = 1'b1; din[d] = 1'b1;
      cnt[d] = 0; p1[d] = 1'b0; p2[d] = 1'b0;
      tail_from[d] = -100; cur_ct[d] = 0; rst_prev[d] = 1'b0;
    end

    // Reset held three cycles with enable high.
    repeat (3) @(negedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0; en[0] = 1'b0; en[1] = 1'b0;
    idle(0, 1);

    // Consecutive bits 1,0,1,1.
    $display("[TB] frame of four, consecutive bits");
    send_frame4();
    idle(0, 4);
    check_log("consecutive", 1);

    // Three idle cycles between bits 2 and 3.
    $display("[TB] frame of four with a gap");
    apply_stimulus(0, 1'b1);
    apply_stimulus(0, 1'b0);
    idle(0, 3);
    apply_stimulus(0, 1'b1);
    apply_stimulus(0, 1'b1);
    idle(0, 4);
    check_log("gapped", 1);

    // Enable held with d_in=1 during the tail, then a back-to-back frame.
    $display("[TB] enable during tail, back-to-back frame");
    send_frame4();
    apply_stimulus(0, 1'b1);
    apply_stimulus(0, 1'b1);
    send_frame4();
    idle(0, 4);
    check_log("tail_ignore", 2);

    // Reset after bit 2 aborts the frame without a tail.
    $display("[TB] reset mid-frame");
    apply_stimulus(0, 1'b1);
    apply_stimulus(0, 1'b0);
    do_reset(0, 2);
    idle(0, 4);
    log0.delete();
    send_frame4();
    idle(0, 4);
    check_log("after_reset", 1);

    // Long frame with random bits and random gaps.
    $display("[TB] frame of 256 random bits");
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1, $urandom_range(1, 3));
      apply_stimulus(1, 1'($urandom_range(0, 1)));
    end
    idle(1, 8);
    chk("dut1.peak_bit_ct", peak1, 256);
    chk("dut1.valid_count", valids1, 258);
    chk("pending_symbols", symq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
